// File: rtl/led_arb_pkg.sv
// Shared types and constants for the LED ownership arbiter.
package led_arb_pkg;

  typedef enum logic [1:0] {
    LOCAL = 2'b00,
    HOST  = 2'b01,
    HEART = 2'b10
  } owner_t;

  localparam int REVOKE_BTN = 2;
  localparam int HEART_BTN  = 3;

  localparam logic [3:0] HB_INIT = 4'b0001;

endpackage

// File: rtl/led_owner_arbiter_pb_debounce.sv
// One push button: 2-flop synchronizer, mismatch-count debouncer and press pulse.
// Output polarity is inverted from the raw pin: clean = 1 means pressed.
module pb_debounce #(
  parameter int DB_CYCLES = 4
) (
  input  logic clk,
  input  logic srst,
  input  logic pb_n,
  output logic clean,
  output logic press
);

  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 1);

  logic [1:0]    sync_reg;
  logic [CW-1:0] cnt_reg;
  logic          stable_reg;
  logic          press_reg;
  logic          pressed_sync;

  // Synchronizer resets to 1 (released) so no spurious press follows reset.
  assign pressed_sync = ~sync_reg[1];

  always_ff @(posedge clk) begin
    if (srst) begin
      sync_reg   <= 2'b11;
      cnt_reg    <= '0;
      stable_reg <= 1'b0;
      press_reg  <= 1'b0;
    end else begin
      sync_reg  <= {sync_reg[0], pb_n};
      press_reg <= 1'b0;
      if (pressed_sync == stable_reg) begin
        cnt_reg <= '0;
      end else if (cnt_reg == DB_LAST) begin
        cnt_reg    <= '0;
        stable_reg <= pressed_sync;
        press_reg  <= pressed_sync;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

  assign clean = stable_reg;
  assign press = press_reg;

endmodule

// File: rtl/led_owner_arbiter.sv
// LED ownership arbiter: button mirror, Nios PIO or heartbeat drives USER_LED.
// Define LED_HEARTBEAT_EN to include the HEART owner and its rotating pattern.
module led_owner_arbiter
  import led_arb_pkg::*;
#(
  parameter int CLK_HZ       = 50_000_000,
  parameter int DEBOUNCE_MS  = 10,
  parameter int HB_PERIOD_MS = 500
) (
  input  logic       SYS_CLK50M,
  input  logic       RESET_EXPN,
  input  logic [3:0] PB,
  input  logic [3:0] nios_led,
  input  logic       nios_req,
  output logic       nios_grant,
  output logic [1:0] owner,
  output logic [3:0] pb_clean,
  output logic [3:0] pb_press,
  output logic [3:0] USER_LED
);

  localparam int DB_CYCLES = CLK_HZ / 1000 * DEBOUNCE_MS;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_pb
      pb_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
        .clk   (SYS_CLK50M),
        .srst  (RESET_EXPN),
        .pb_n  (PB[gi]),
        .clean (pb_clean[gi]),
        .press (pb_press[gi])
      );
    end
  endgenerate

  owner_t     state_reg, state_next;
  logic       lockout_reg, lockout_next;
  logic [3:0] led_reg, led_next;
  logic       grant_reg;
  logic       host_req;
  logic       revoke;

  assign host_req = nios_req && !lockout_reg;
  assign revoke   = (state_reg == HOST) && pb_press[REVOKE_BTN];

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      LOCAL: begin
        if (host_req) state_next = HOST;
`ifdef LED_HEARTBEAT_EN
        else if (pb_press[HEART_BTN]) state_next = HEART;
`endif
      end
      HOST: begin
        if (revoke || !nios_req) state_next = LOCAL;
      end
`ifdef LED_HEARTBEAT_EN
      HEART: begin
        if (host_req) state_next = HOST;
        else if (pb_press[HEART_BTN]) state_next = LOCAL;
      end
`endif
      default: state_next = LOCAL;
    endcase
  end

  // Revoke wins over the clear so a held-off host must drop its request first.
  always_comb begin
    lockout_next = lockout_reg;
    if (revoke) lockout_next = 1'b1;
    else if (!nios_req) lockout_next = 1'b0;
  end

`ifdef LED_HEARTBEAT_EN
  localparam int HB_CYCLES = CLK_HZ / 1000 * HB_PERIOD_MS;
  localparam int HW = (HB_CYCLES > 1) ? $clog2(HB_CYCLES) : 1;
  localparam logic [HW-1:0] HB_LAST = HW'(HB_CYCLES - 1);

  logic [HW-1:0] hb_cnt_reg, hb_cnt_next;
  logic [3:0]    pat_reg, pat_next;

  // Counter and pattern restart on every entry and idle at their initial values.
  always_comb begin
    hb_cnt_next = '0;
    pat_next    = HB_INIT;
    if (state_reg == HEART && state_next == HEART) begin
      if (hb_cnt_reg == HB_LAST) begin
        pat_next = {pat_reg[2:0], pat_reg[3]};
      end else begin
        hb_cnt_next = hb_cnt_reg + 1'b1;
        pat_next    = pat_reg;
      end
    end
  end

  always_ff @(posedge SYS_CLK50M) begin
    if (RESET_EXPN) begin
      hb_cnt_reg <= '0;
      pat_reg    <= HB_INIT;
    end else begin
      hb_cnt_reg <= hb_cnt_next;
      pat_reg    <= pat_next;
    end
  end
`endif

  always_comb begin
    led_next = pb_clean;
    unique case (state_next)
      LOCAL:   led_next = pb_clean;
      HOST:    led_next = nios_led;
`ifdef LED_HEARTBEAT_EN
      HEART:   led_next = pat_next;
`endif
      default: led_next = pb_clean;
    endcase
  end

  always_ff @(posedge SYS_CLK50M) begin
    if (RESET_EXPN) begin
      state_reg   <= LOCAL;
      lockout_reg <= 1'b0;
      led_reg     <= 4'b0000;
      grant_reg   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      lockout_reg <= lockout_next;
      led_reg     <= led_next;
      grant_reg   <= (state_next == HOST);
    end
  end

  assign owner      = state_reg;
  assign nios_grant = grant_reg;
  assign USER_LED   = led_reg;

endmodule

// File: tb/tb_led_owner_arbiter.sv
// Directed bench for led_owner_arbiter with small debounce/heartbeat windows.
module tb_led_owner_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] pb;
  logic [3:0] nios_led;
  logic       nios_req;
  logic       nios_grant;
  logic [1:0] owner;
  logic [3:0] pb_clean;
  logic [3:0] pb_press;
  logic [3:0] user_led;

  int checks = 0;
  int errors = 0;

  led_owner_arbiter #(
    .CLK_HZ(1000), .DEBOUNCE_MS(4), .HB_PERIOD_MS(8)
  ) dut (
    .SYS_CLK50M (clk),
    .RESET_EXPN (rst),
    .PB         (pb),
    .nios_led   (nios_led),
    .nios_req   (nios_req),
    .nios_grant (nios_grant),
    .owner      (owner),
    .pb_clean   (pb_clean),
    .pb_press   (pb_press),
    .USER_LED   (user_led)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %b expected %b", tag, got, exp);
    end else begin
      $display("ok   %s = %b", tag, got);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Waits for pb_clean to settle, checks latency window and a single press pulse,
  // then leaves the bench one edge after the pulse (the FSM has acted on it).
  task automatic wait_db(input string tag, input logic [3:0] exp_clean, input logic [3:0] exp_press);
    int  n   = 0;
    bit  hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      step(1);
      n++;
      if (pb_clean == exp_clean) hit = 1'b1;
    end
    chk({tag, " latency"}, 4'(hit && n >= 5 && n <= 7), 4'd1);
    chk({tag, " press"}, pb_press, exp_press);
    step(1);
    chk({tag, " press end"}, pb_press, 4'b0000);
  endtask

  initial begin
    logic [3:0] seen;
    bit         hit;

    // Reset with all buttons held down.
    rst = 1'b1; pb = 4'b0000; nios_led = 4'b0000; nios_req = 1'b0;
    step(3);
    chk("rst led", user_led, 4'b0000);
    chk("rst grant", 4'(nios_grant), 4'd0);
    chk("rst owner", 4'(owner), 4'd0);
    chk("rst clean", pb_clean, 4'b0000);
    chk("rst press", pb_press, 4'b0000);
    rst = 1'b0;
    wait_db("rel all", 4'b1111, 4'b1111);
`ifdef LED_HEARTBEAT_EN
    chk("rel owner", 4'(owner), 4'd2);
    chk("rel led", user_led, 4'b0001);
`else
    chk("rel owner", 4'(owner), 4'd0);
    chk("rel led", user_led, 4'b1111);
`endif

    // Clean restart with buttons released.
    rst = 1'b1; pb = 4'b1111;
    step(2);
    rst = 1'b0;
    step(1);
    chk("rst2 owner", 4'(owner), 4'd0);

    // Short glitch must be filtered.
    pb = 4'b1110;
    step(2);
    pb = 4'b1111;
    seen = 4'b0000;
    for (int i = 0; i < 8; i++) begin
      step(1);
      seen = seen | pb_clean | pb_press;
    end
    chk("glitch", seen, 4'b0000);

    pb = 4'b1110;
    wait_db("pb0", 4'b0001, 4'b0001);
    chk("mirror led", user_led, 4'b0001);

    // Host ownership and release.
    nios_led = 4'b1010; nios_req = 1'b1;
    step(1);
    chk("host owner", 4'(owner), 4'd1);
    chk("host grant", 4'(nios_grant), 4'd1);
    chk("host led", user_led, 4'b1010);
    nios_led = 4'b0101;
    step(1);
    chk("host led follow", user_led, 4'b0101);
    nios_req = 1'b0;
    step(1);
    chk("drop owner", 4'(owner), 4'd0);
    chk("drop grant", 4'(nios_grant), 4'd0);
    chk("drop led", user_led, 4'b0001);

    // Revoke and lockout.
    nios_req = 1'b1;
    step(1);
    chk("req2 owner", 4'(owner), 4'd1);
    pb = 4'b1010;
    wait_db("revoke", 4'b0101, 4'b0100);
    chk("revoke owner", 4'(owner), 4'd0);
    chk("revoke grant", 4'(nios_grant), 4'd0);
    pb = 4'b1110;
    step(3);
    chk("lockout hold", 4'(owner), 4'd0);
    nios_req = 1'b0;
    step(1);
    nios_req = 1'b1;
    step(1);
    chk("relock owner", 4'(owner), 4'd1);
    chk("relock grant", 4'(nios_grant), 4'd1);
    nios_req = 1'b0;
    step(8);
    chk("back local", 4'(owner), 4'd0);

    // Heartbeat rotation.
    pb = 4'b0110;
    wait_db("heart", 4'b1001, 4'b1000);
`ifdef LED_HEARTBEAT_EN
    chk("hb owner", 4'(owner), 4'd2);
    chk("hb led0", user_led, 4'b0001);
    step(7);
    chk("hb led7", user_led, 4'b0001);
    step(1);
    chk("hb led8", user_led, 4'b0010);
    step(8);
    chk("hb led16", user_led, 4'b0100);
    step(8);
    chk("hb led24", user_led, 4'b1000);
    step(8);
    chk("hb led32", user_led, 4'b0001);
`else
    chk("hb owner", 4'(owner), 4'd0);
    chk("hb led", user_led, 4'b1001);
`endif
    pb = 4'b1110;
    step(8);
    pb = 4'b0110;
    wait_db("heart exit", 4'b1001, 4'b1000);
    chk("exit owner", 4'(owner), 4'd0);

    // Host request in the same cycle as pb_press[3].
    pb = 4'b1110;
    step(8);
    pb = 4'b0110;
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      step(1);
      if (pb_press != 4'b0000) hit = 1'b1;
    end
    chk("simul press", pb_press, 4'b1000);
    nios_req = 1'b1;
    step(1);
    chk("simul owner", 4'(owner), 4'd1);

    // Reset clears lockout.
    pb = 4'b1011;
    wait_db("revoke2", 4'b0100, 4'b0100);
    chk("revoke2 owner", 4'(owner), 4'd0);
    step(2);
    chk("revoke2 hold", 4'(owner), 4'd0);
    pb = 4'b1111;
    rst = 1'b1;
    step(2);
    chk("rst3 owner", 4'(owner), 4'd0);
    chk("rst3 grant", 4'(nios_grant), 4'd0);
    chk("rst3 clean", pb_clean, 4'b0000);
    chk("rst3 led", user_led, 4'b0000);
    rst = 1'b0;
    step(1);
    chk("post rst owner", 4'(owner), 4'd1);
    chk("post rst grant", 4'(nios_grant), 4'd1);
    chk("post rst led", user_led, 4'b0101);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
